// File: rtl/cxt_rsp_arbiter.sv
// cxt_rsp_arbiter
//   Merges four context response streams (QPC, CQC, EQC, ICM-mapping) into a
//   single stream towards CEU. Arbitration is round-robin at packet
//   granularity: once a source is granted it keeps the lock until its
//   last beat is accepted, so packets never interleave. The output is a
//   single pipeline register; accepted beats appear one cycle later.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   <src>_rsp_valid/head/last/data   input streams, src = qpc(0), cqc(1), eqc(2), mapping(3)
//   <src>_rsp_ready          accept for each input stream
//   ceu_rsp_valid/head/last/data     merged output stream
//   ceu_rsp_ready            output accept from CEU
//   pkt_cnt                  four 16-bit completed-packet counters, source n at [16n+15:16n]
//
// Configuration
//   CXT_RSP_ARB_PKT_CNT_EN   when defined, builds the saturating per-source packet
//                            counters; otherwise pkt_cnt reads as zero.

`ifndef CEU_CXT_HEAD_WIDTH
`define CEU_CXT_HEAD_WIDTH 64
`endif
`ifndef CEU_CXT_DATA_WIDTH
`define CEU_CXT_DATA_WIDTH 256
`endif

module cxt_rsp_arbiter #(
    parameter int HEAD_W = `CEU_CXT_HEAD_WIDTH,
    parameter int DATA_W = `CEU_CXT_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              qpc_rsp_valid,
    input  logic [HEAD_W-1:0] qpc_rsp_head,
    input  logic              qpc_rsp_last,
    input  logic [DATA_W-1:0] qpc_rsp_data,
    output logic              qpc_rsp_ready,

    input  logic              cqc_rsp_valid,
    input  logic [HEAD_W-1:0] cqc_rsp_head,
    input  logic              cqc_rsp_last,
    input  logic [DATA_W-1:0] cqc_rsp_data,
    output logic              cqc_rsp_ready,

    input  logic              eqc_rsp_valid,
    input  logic [HEAD_W-1:0] eqc_rsp_head,
    input  logic              eqc_rsp_last,
    input  logic [DATA_W-1:0] eqc_rsp_data,
    output logic              eqc_rsp_ready,

    input  logic              mapping_rsp_valid,
    input  logic [HEAD_W-1:0] mapping_rsp_head,
    input  logic              mapping_rsp_last,
    input  logic [DATA_W-1:0] mapping_rsp_data,
    output logic              mapping_rsp_ready,

    output logic              ceu_rsp_valid,
    output logic [HEAD_W-1:0] ceu_rsp_head,
    output logic              ceu_rsp_last,
    output logic [DATA_W-1:0] ceu_rsp_data,
    input  logic              ceu_rsp_ready,

    output logic [63:0]       pkt_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QPC     = 3'd1,
        ST_CQC     = 3'd2,
        ST_EQC     = 3'd3,
        ST_MAPPING = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [HEAD_W-1:0] out_head_q, out_head_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [3:0]        src_valid;
    logic [3:0]        src_last;
    logic [HEAD_W-1:0] src_head [4];
    logic [DATA_W-1:0] src_data [4];

    logic [1:0]        gnt_idx;
    logic              locked;
    logic              load_en;
    logic              gnt_ready;
    logic              accept;
    logic              accept_last;
    logic [1:0]        pick_idx;
    logic              pick_found;

    assign src_valid   = {mapping_rsp_valid, eqc_rsp_valid, cqc_rsp_valid, qpc_rsp_valid};
    assign src_last    = {mapping_rsp_last, eqc_rsp_last, cqc_rsp_last, qpc_rsp_last};
    assign src_head[0] = qpc_rsp_head;
    assign src_head[1] = cqc_rsp_head;
    assign src_head[2] = eqc_rsp_head;
    assign src_head[3] = mapping_rsp_head;
    assign src_data[0] = qpc_rsp_data;
    assign src_data[1] = cqc_rsp_data;
    assign src_data[2] = eqc_rsp_data;
    assign src_data[3] = mapping_rsp_data;

    always_comb begin
        case (state_q)
            ST_CQC:     gnt_idx = 2'd1;
            ST_EQC:     gnt_idx = 2'd2;
            ST_MAPPING: gnt_idx = 2'd3;
            default:    gnt_idx = 2'd0;
        endcase
    end

    assign locked      = (state_q != ST_IDLE);
    assign load_en     = !out_valid_q || ceu_rsp_ready;
    assign gnt_ready   = locked && load_en;
    assign accept      = gnt_ready && src_valid[gnt_idx];
    assign accept_last = accept && src_last[gnt_idx];

    assign qpc_rsp_ready     = gnt_ready && (gnt_idx == 2'd0);
    assign cqc_rsp_ready     = gnt_ready && (gnt_idx == 2'd1);
    assign eqc_rsp_ready     = gnt_ready && (gnt_idx == 2'd2);
    assign mapping_rsp_ready = gnt_ready && (gnt_idx == 2'd3);

    // Round-robin search starting one past the last packet's owner; the
    // owner itself is checked last (offset 4 wraps to rr_q).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!pick_found && src_valid[rr_q + 2'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d = state_t'({1'b0, pick_idx} + 3'd1);
            end
        end else if (accept_last) begin
            state_d = ST_IDLE;
            rr_d    = gnt_idx;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_head_d  = out_head_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_head_d  = src_head[gnt_idx];
            out_last_d  = src_last[gnt_idx];
            out_data_d  = src_data[gnt_idx];
        end else if (ceu_rsp_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 2'd3;
            out_valid_q <= 1'b0;
            out_head_q  <= '0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_head_q  <= out_head_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign ceu_rsp_valid = out_valid_q;
    assign ceu_rsp_head  = out_head_q;
    assign ceu_rsp_last  = out_last_q;
    assign ceu_rsp_data  = out_data_q;

`ifdef CXT_RSP_ARB_PKT_CNT_EN
    logic [3:0][15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int n = 0; n < 4; n++) begin
            if (accept_last && (gnt_idx == 2'(n)) && (cnt_q[n] != 16'hFFFF)) begin
                cnt_d[n] = cnt_q[n] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_cxt_rsp_arbiter.sv
module tb_cxt_rsp_arbiter;
    localparam int HW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    sv = '0;
    logic [3:0]    sl = '0;
    logic [HW-1:0] sh [4];
    logic [DW-1:0] sd [4];
    logic          crdy = 1'b0;
    logic          q_r, c_r, e_r, m_r;
    logic [3:0]    rdy;
    logic          ceu_v, ceu_l;
    logic [HW-1:0] ceu_h;
    logic [DW-1:0] ceu_d;
    logic [63:0]   pkt_cnt;

    always #5 clk = ~clk;
    assign rdy = {m_r, e_r, c_r, q_r};

    cxt_rsp_arbiter #(.HEAD_W(HW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .qpc_rsp_valid(sv[0]), .qpc_rsp_head(sh[0]), .qpc_rsp_last(sl[0]), .qpc_rsp_data(sd[0]), .qpc_rsp_ready(q_r),
        .cqc_rsp_valid(sv[1]), .cqc_rsp_head(sh[1]), .cqc_rsp_last(sl[1]), .cqc_rsp_data(sd[1]), .cqc_rsp_ready(c_r),
        .eqc_rsp_valid(sv[2]), .eqc_rsp_head(sh[2]), .eqc_rsp_last(sl[2]), .eqc_rsp_data(sd[2]), .eqc_rsp_ready(e_r),
        .mapping_rsp_valid(sv[3]), .mapping_rsp_head(sh[3]), .mapping_rsp_last(sl[3]), .mapping_rsp_data(sd[3]),
        .mapping_rsp_ready(m_r),
        .ceu_rsp_valid(ceu_v), .ceu_rsp_head(ceu_h), .ceu_rsp_last(ceu_l), .ceu_rsp_data(ceu_d),
        .ceu_rsp_ready(crdy),
        .pkt_cnt(pkt_cnt)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: which source holds the packet lock (-1 = none), who
    // finished the last packet, and the contents of the output slot.
    int            m_lock;
    int            m_rr;
    bit            m_ov;
    logic [HW-1:0] m_oh;
    logic          m_ol;
    logic [DW-1:0] m_od;
    logic [15:0]   m_cnt [4];
    int            acc_src;

    // Packet generators: per source, packet length, beat index, packet number, packets left.
    int mode;   // 0 manual, 1 generators, 2 random
    int gen_len [4];
    int gen_beat [4];
    int gen_pkt [4];
    int gen_left [4];

    logic [HW-1:0] log_h [$];
    logic [DW-1:0] log_d [$];
    bit            log_l [$];
    int            eqc_acc [$];

    typedef struct {
        logic [3:0]    vld;
        logic [HW-1:0] hd;
        logic          lst;
        logic [DW-1:0] dat;
        logic          cr;
        logic [3:0]    e_rdy;
        logic          e_ov;
        logic [HW-1:0] e_oh;
        logic          e_ol;
        logic [DW-1:0] e_od;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] exp_cnt();
`ifdef CXT_RSP_ARB_PKT_CNT_EN
        return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        m_lock = -1;
        m_rr   = 3;
        m_ov   = 0;
        m_oh   = '0;
        m_ol   = 0;
        m_od   = '0;
        for (int s = 0; s < 4; s++) m_cnt[s] = 16'd0;
    endtask

    task automatic model_update();
        bit load;
        bit found;
        int s;
        load    = !m_ov || crdy;
        acc_src = -1;
        if (m_lock >= 0 && sv[m_lock] && load) begin
            acc_src = m_lock;
            m_ov = 1;
            m_oh = sh[m_lock];
            m_ol = sl[m_lock];
            m_od = sd[m_lock];
            if (sl[m_lock]) begin
                if (m_cnt[m_lock] != 16'hFFFF) m_cnt[m_lock] = m_cnt[m_lock] + 16'd1;
                m_rr   = m_lock;
                m_lock = -1;
            end
        end else begin
            if (crdy) m_ov = 0;
            if (m_lock < 0) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    s = (m_rr + k) % 4;
                    if (!found && sv[s]) begin
                        found  = 1;
                        m_lock = s;
                    end
                end
            end
        end
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < 4; s++) begin
            if (mode == 1) begin
                sv[s] = (gen_left[s] > 0);
                sh[s] = {2'(s), 6'(gen_pkt[s])};
                sl[s] = (gen_beat[s] == gen_len[s] - 1);
                sd[s] = {8'(gen_pkt[s]), 8'(gen_beat[s])};
            end else if (mode == 2) begin
                sv[s] = 1'($urandom_range(0, 1));
                sh[s] = HW'($urandom);
                sl[s] = ($urandom_range(0, 2) == 0);
                sd[s] = DW'($urandom);
            end
        end
        if (mode == 2) crdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic gen_start(input int s, input int len, input int npk);
        gen_len[s]  = len;
        gen_left[s] = npk;
        gen_beat[s] = 0;
        gen_pkt[s]  = 0;
    endtask

    task automatic check_neg();
        @(negedge clk);
        cyc++;
        for (int s = 0; s < 4; s++)
            chk($sformatf("ready%0d", s), rdy[s], (m_lock == s) && (!m_ov || crdy));
        chk("out_valid", ceu_v, m_ov);
        if (m_ov) begin
            chk("out_head", ceu_h, m_oh);
            chk("out_last", ceu_l, m_ol);
            chk("out_data", ceu_d, m_od);
        end
        chk("pkt_cnt", pkt_cnt, exp_cnt());
        if (ceu_v === 1'b1 && crdy) begin
            log_h.push_back(ceu_h);
            log_d.push_back(ceu_d);
            log_l.push_back(ceu_l);
        end
        if (rdy[2] && sv[2]) eqc_acc.push_back(cyc);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        if (mode == 1 && acc_src >= 0) begin
            gen_beat[acc_src]++;
            if (gen_beat[acc_src] == gen_len[acc_src]) begin
                gen_beat[acc_src] = 0;
                gen_pkt[acc_src]++;
                gen_left[acc_src]--;
            end
        end
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check_neg();
            advance();
        end
    endtask

    // Asserts reset between edges, checks that everything clears at once,
    // and releases it one cycle later.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", ceu_v, 0);
        chk("rst_head", ceu_h, 0);
        chk("rst_last", ceu_l, 0);
        chk("rst_data", ceu_d, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int s = 0; s < 4; s++) gen_start(s, 1, 0);
        mode = 1;
        drive_inputs();
    endtask

    initial begin
        int bad;
        for (int s = 0; s < 4; s++) begin
            sh[s] = '0;
            sd[s] = '0;
            gen_start(s, 1, 0);
        end
        model_reset();
        mode = 0;

        //     vld      hd     lst  dat       cr    e_rdy    ov    oh     ol    od
        tv[0] = '{4'b0001, 8'hA0, 1'b0, 16'h1000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[1] = '{4'b0001, 8'hA0, 1'b0, 16'h1000, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[2] = '{4'b0001, 8'hA1, 1'b0, 16'h1001, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b0, 16'h1000};
        tv[3] = '{4'b0001, 8'hA2, 1'b1, 16'h1002, 1'b1, 4'b0001, 1'b1, 8'hA1, 1'b0, 16'h1001};
        tv[4] = '{4'b0000, 8'h00, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'hA2, 1'b1, 16'h1002};
        tv[5] = '{4'b0000, 8'h00, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[6] = '{4'b0010, 8'hB0, 1'b1, 16'h2000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[7] = '{4'b0010, 8'hB0, 1'b1, 16'h2000, 1'b1, 4'b0010, 1'b0, 8'h00, 1'b0, 16'h0000};
        tv[8] = '{4'b0000, 8'h00, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b1, 8'hB0, 1'b1, 16'h2000};
        tv[9] = '{4'b0000, 8'h00, 1'b0, 16'h0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 16'h0000};

        #2;
        do_reset();

        // 3-beat QPC packet then a single-beat CQC packet, cycle by cycle.
        mode = 0;
        for (int i = 0; i < 10; i++) begin
            sv = tv[i].vld;
            for (int s = 0; s < 4; s++) begin
                sh[s] = tv[i].hd;
                sl[s] = tv[i].lst;
                sd[s] = tv[i].dat;
            end
            crdy = tv[i].cr;
            check_neg();
            chk($sformatf("tbl%0d_rdy", i), rdy, tv[i].e_rdy);
            chk($sformatf("tbl%0d_valid", i), ceu_v, tv[i].e_ov);
            if (tv[i].e_ov) begin
                chk($sformatf("tbl%0d_head", i), ceu_h, tv[i].e_oh);
                chk($sformatf("tbl%0d_last", i), ceu_l, tv[i].e_ol);
                chk($sformatf("tbl%0d_data", i), ceu_d, tv[i].e_od);
            end
            advance();
        end

        // All four sources with continuous 2-beat packets: strict rotation.
        do_reset();
        crdy = 1'b1;
        log_h.delete(); log_d.delete(); log_l.delete();
        for (int s = 0; s < 4; s++) gen_start(s, 2, 2);
        drive_inputs();
        run(40);
        chk("rot_beats", log_h.size(), 16);
        for (int k = 0; k < 8; k++) begin
            if (2 * k + 1 < log_h.size()) begin
                chk($sformatf("rot_src%0d_b0", k), log_h[2*k][7:6], k % 4);
                chk($sformatf("rot_src%0d_b1", k), log_h[2*k+1][7:6], k % 4);
                chk($sformatf("rot_last%0d", k), {log_l[2*k], log_l[2*k+1]}, 2'b01);
            end
        end

        // CQC 6-beat packet with a 5-cycle CEU stall in the middle.
        log_h.delete(); log_d.delete(); log_l.delete();
        gen_start(1, 6, 1);
        drive_inputs();
        for (int t = 0; t < 20 && gen_beat[1] < 2; t++) run(1);
        chk("stall_reach", gen_beat[1], 2);
        crdy = 1'b0;
        run(5);
        crdy = 1'b1;
        run(15);
        chk("stall_beats", log_d.size(), 6);
        for (int j = 0; j < 6; j++) begin
            if (j < log_d.size()) begin
                chk($sformatf("stall_seq%0d", j), log_d[j][7:0], j);
                chk($sformatf("stall_last%0d", j), log_l[j], j == 5);
                chk($sformatf("stall_src%0d", j), log_h[j][7:6], 1);
            end
        end

        // Back-to-back single-beat EQC packets: one grant every 2nd cycle.
        eqc_acc.delete();
        gen_start(2, 1, 10);
        drive_inputs();
        run(24);
        chk("eqc_grants", eqc_acc.size(), 10);
        bad = 0;
        for (int j = 1; j < eqc_acc.size(); j++)
            if (eqc_acc[j] - eqc_acc[j-1] != 2) bad++;
        chk("eqc_spacing", bad, 0);

        // Reset in the middle of a MAPPING packet; QPC must win first afterwards.
        gen_start(0, 1, 1);
        drive_inputs();
        run(4);
        gen_start(3, 4, 1);
        drive_inputs();
        for (int t = 0; t < 10 && gen_beat[3] < 1; t++) run(1);
        chk("map_reach", gen_beat[3], 1);
        do_reset();
        log_h.delete(); log_d.delete(); log_l.delete();
        for (int s = 0; s < 4; s++) gen_start(s, 1, 1);
        drive_inputs();
        run(14);
        chk("post_rst_pkts", log_h.size(), 4);
        if (log_h.size() > 0) chk("post_rst_first", log_h[0][7:6], 0);

        // Packet counters: 3 QPC + 1 EQC packets after a fresh reset.
        do_reset();
        gen_start(0, 2, 3);
        gen_start(2, 1, 1);
        drive_inputs();
        run(30);
`ifdef CXT_RSP_ARB_PKT_CNT_EN
        chk("pkt_cnt_final", pkt_cnt, {16'd0, 16'd1, 16'd0, 16'd3});
`else
        chk("pkt_cnt_final", pkt_cnt, 64'd0);
`endif

        // Random traffic against the model.
        mode = 2;
        drive_inputs();
        run(3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cxt_rsp_arbiter.md
CXT_RSP_ARBITER -- requirements
Module: cxt_rsp_arbiter

Interface
REQ-001 Parameter HEAD_W, default `CEU_CXT_HEAD_WIDTH, response head width.
REQ-002 Parameter DATA_W, default `CEU_CXT_DATA_WIDTH, response data width.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 qpc_rsp_valid/head/last/data  input  1/HEAD_W/1/DATA_W  QPC response stream (source 0).
REQ-006 qpc_rsp_ready  output  1  QPC stream accept.
REQ-007 cqc_rsp_valid/head/last/data, cqc_rsp_ready  in/out  same widths  CQC response stream (source 1).
REQ-008 eqc_rsp_valid/head/last/data, eqc_rsp_ready  in/out  same widths  EQC response stream (source 2).
REQ-009 mapping_rsp_valid/head/last/data, mapping_rsp_ready  in/out  same widths  ICM-mapping response stream (source 3).
REQ-010 ceu_rsp_valid/head/last/data  output  1/HEAD_W/1/DATA_W  merged response stream to CEU.
REQ-011 ceu_rsp_ready  input  1  CEU accept.
REQ-012 pkt_cnt  output  64  four 16-bit per-source packet counters, source n at [16n+15:16n].

Function
REQ-013 FSM states IDLE, QPC, CQC, EQC, MAPPING; each source state owns the packet lock.
REQ-014 In IDLE, if any source valid, next state = first valid source searching cyclically from (rr_ptr+1) mod 4; else stay IDLE.
REQ-015 In a source state, transition to IDLE on the cycle that source's beat with last=1 is accepted (valid & ready); rr_ptr <= that source index on the same edge.
REQ-016 Packets never interleave: no other source is granted until the locked packet's last beat is accepted.
REQ-017 Output stage is a single pipeline register: load_en = !ceu_rsp_valid | ceu_rsp_ready.
REQ-018 Granted source ready = load_en; all non-granted readies = 0; all readies = 0 in IDLE.
REQ-019 Accepted beat appears on ceu_rsp_* exactly 1 cycle after acceptance; head, last and data are copied unmodified.
REQ-020 ceu_rsp_valid clears when ceu_rsp_ready=1 and no new beat is loaded; head/data hold while valid=1 and ready=0.
REQ-021 Full throughput within a packet (1 beat/cycle with ceu_rsp_ready held high); one IDLE arbitration bubble between packets.
REQ-022 Valid deassertion mid-packet by the granted source stalls the lock; no re-arbitration occurs.
REQ-023 Single-beat packet (valid & last on first beat) enters the source state, is accepted, and returns to IDLE the following edge.

Reset
REQ-024 On rst: state=IDLE, rr_ptr=3 (first search starts at QPC), ceu_rsp_valid=0, ceu_rsp_head/last/data=0, all *_rsp_ready=0, pkt_cnt=0.
REQ-025 rst asserted mid-packet discards the remaining packet state; after release the next arbitration starts fresh from REQ-024 values.

Configuration
REQ-026 Macro CXT_RSP_ARB_PKT_CNT_EN: when defined, pkt_cnt[n] increments by 1 on each accepted last beat of source n, saturating at 16'hFFFF.
REQ-027 Without CXT_RSP_ARB_PKT_CNT_EN, pkt_cnt is tied to 64'd0 and no counter flops are built; all other behaviour identical.

Verification
REQ-028 Post-reset, qpc 3-beat packet, ceu_rsp_ready=1 -> grant QPC, beats out on consecutive cycles 1 cycle after accept, last on 3rd beat, FSM back to IDLE.
REQ-029 All four sources present 2-beat packets simultaneously, continuously -> output order QPC, CQC, EQC, MAPPING, QPC... with no interleave.
REQ-030 CQC packet in progress, ceu_rsp_ready=0 for 5 cycles -> cqc_rsp_ready=0 after the register fills, output head/data stable, no beat lost or duplicated.
REQ-031 EQC single-beat packets back to back, MAPPING idle -> EQC granted every 2nd cycle (one bubble), rr_ptr=2 after each.
REQ-032 rst pulsed on 2nd beat of 4-beat MAPPING packet -> all outputs 0 immediately; next QPC packet granted first after release.
REQ-033 With CXT_RSP_ARB_PKT_CNT_EN, 3 QPC + 1 EQC packets -> pkt_cnt[15:0]=3, [47:32]=1; without macro -> pkt_cnt=0.
